// File: rtl/iforest_pkg.sv
// iforest_pkg: shared widths, state encoding and helpers
// for the isolation-forest tree scheduler.
package iforest_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_NUM_TREES = 4;
  localparam int DEF_PATH_W    = 4;
  localparam int DEF_TIMEOUT   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESULT
  } state_e;

  // Ceiling log2, never below 1 so widths stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/iforest_watchdog.sv
// iforest_watchdog: per-job cycle counter that flags
// the last allowed WAIT cycle of an engine job.
module iforest_watchdog
  import iforest_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == LAST);

  // Clear wins; count while enabled, saturating at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/iforest_tree_scheduler.sv
// iforest_tree_scheduler: shares one tree engine across
// NUM_TREES trees per sample and scores the summed path.
module iforest_tree_scheduler
  import iforest_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_TREES = DEF_NUM_TREES,
  parameter int PATH_W    = DEF_PATH_W,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  localparam int TREE_W   = clog2(NUM_TREES),
  localparam int ACC_W    = PATH_W + TREE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [ACC_W-1:0]  threshold,
  output logic              eng_start,
  output logic [TREE_W-1:0] eng_tree,
  output logic [DATA_W-1:0] eng_data,
  input  logic              eng_done,
  input  logic [PATH_W-1:0] eng_path_len,
  output logic              r_valid,
  input  logic              r_ready,
  output logic              r_anomaly,
  output logic [ACC_W-1:0]  r_score,
  output logic              r_err
);

  localparam logic [TREE_W-1:0] LAST_TREE =
    TREE_W'(NUM_TREES - 1);
  localparam logic [ACC_W-1:0] PATH_MAX =
    ACC_W'((1 << PATH_W) - 1);

  state_e            state_q, state_d;
  logic [TREE_W-1:0] tree_q, tree_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  thr_q, thr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              anom_q, anom_d;
  logic              rdy_q, rdy_d;
  logic              wd_clr, wd_en, wd_expire;
  logic              step;

  iforest_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  assign s_ready   = rdy_q;
  assign eng_start = (state_q == ST_ISSUE);
  assign eng_tree  = tree_q;
  assign eng_data  = data_q;
  assign r_valid   = (state_q == ST_RESULT);
  assign r_score   = acc_q;
  assign r_anomaly = anom_q;
  assign r_err     = err_q;

  // Sequencing, accumulation and watchdog control.
  always_comb begin
    state_d = state_q;
    tree_d  = tree_q;
    acc_d   = acc_q;
    thr_d   = thr_q;
    data_d  = data_q;
    err_d   = err_q;
    anom_d  = anom_q;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s_valid && rdy_q) begin
          data_d  = s_data;
          thr_d   = threshold;
          acc_d   = '0;
          err_d   = 1'b0;
          anom_d  = 1'b0;
          tree_d  = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_clr  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_en = 1'b1;
        if (eng_done) begin
          acc_d = acc_q + {{TREE_W{1'b0}}, eng_path_len};
          step  = 1'b1;
        end else if (wd_expire) begin
          acc_d = acc_q + PATH_MAX;
          err_d = 1'b1;
          step  = 1'b1;
        end
        if (step) begin
          if (tree_q == LAST_TREE) begin
            anom_d  = (acc_d < thr_q);
            state_d = ST_RESULT;
          end else begin
            tree_d  = tree_q + 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_RESULT: begin
        if (r_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tree_q  <= '0;
      acc_q   <= '0;
      thr_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      anom_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tree_q  <= tree_d;
      acc_q   <= acc_d;
      thr_q   <= thr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      anom_q  <= anom_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_iforest_tree_scheduler.sv
// tb_iforest_tree_scheduler: directed vectors against
// a behavioural tree engine with per-tree latency.
module tb_iforest_tree_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic [5:0] threshold = '0;
  logic       eng_start;
  logic [1:0] eng_tree;
  logic [7:0] eng_data;
  logic       m_done = 1'b0;
  logic       x_done = 1'b0;
  logic [3:0] m_len = '0;
  logic [3:0] x_len = '0;
  logic       r_valid;
  logic       r_ready = 1'b0;
  logic       r_anomaly;
  logic [5:0] r_score;
  logic       r_err;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int lat [4];
  int plen [4];
  int cnt = 0;
  int cur = 0;
  int issued = 0;
  int data_bad = 0;
  logic [7:0] exp_data = '0;

  iforest_tree_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .threshold    (threshold),
    .eng_start    (eng_start),
    .eng_tree     (eng_tree),
    .eng_data     (eng_data),
    .eng_done     (m_done | x_done),
    .eng_path_len (x_done ? x_len : m_len),
    .r_valid      (r_valid),
    .r_ready      (r_ready),
    .r_anomaly    (r_anomaly),
    .r_score      (r_score),
    .r_err        (r_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine: done pulses lat[t] cycles after start (0 = never).
  always @(negedge clk) begin
    m_done = 1'b0;
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        m_done = 1'b1;
        m_len  = 4'(plen[cur]);
      end
    end
    if (eng_start) begin
      cur    = int'(eng_tree);
      cnt    = lat[cur];
      issued = issued | (1 << cur);
      if (eng_data !== exp_data) data_bad++;
    end
  end

  task automatic check(input string tag, input int got,
                       input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic cfg(input int l0, input int l1,
                     input int l2, input int l3,
                     input int p0, input int p1,
                     input int p2, input int p3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    plen[0] = p0; plen[1] = p1;
    plen[2] = p2; plen[3] = p3;
  endtask

  task automatic send(input logic [7:0] d,
                      input logic [5:0] thr);
    int n;
    n = 0;
    @(negedge clk);
    exp_data  = d;
    issued    = 0;
    data_bad  = 0;
    s_data    = d;
    threshold = thr;
    s_valid   = 1'b1;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("accept_timeout", 0, 1);
    acc_cyc = cyc;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic result(input string tag, input int e_score,
                        input int e_anom, input int e_err,
                        input int e_lat);
    int n;
    n = 0;
    while (!r_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rvalid"}, int'(r_valid), 1);
    check({tag, "_latency"}, cyc - acc_cyc, e_lat);
    check({tag, "_score"}, int'(r_score), e_score);
    check({tag, "_anomaly"}, int'(r_anomaly), e_anom);
    check({tag, "_err"}, int'(r_err), e_err);
    check({tag, "_issued"}, issued, 15);
    check({tag, "_eng_data"}, data_bad, 0);
  endtask

  task automatic take(input string tag);
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    check({tag, "_rvalid_drop"}, int'(r_valid), 0);
    check({tag, "_idle_ready"}, int'(s_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int bad;
    cfg(1, 1, 1, 1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_s_ready", int'(s_ready), 0);
    check("rst_eng_start", int'(eng_start), 0);
    check("rst_r_valid", int'(r_valid), 0);
    check("rst_r_score", int'(r_score), 0);
    check("rst_eng_data", int'(eng_data), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_s_ready", int'(s_ready), 1);

    cfg(1, 1, 1, 1, 3, 4, 2, 5);
    send(8'hA5, 6'd10);
    result("nom", 14, 0, 0, 9);
    take("nom");

    cfg(1, 1, 1, 1, 1, 2, 1, 2);
    send(8'h3C, 6'd10);
    result("anom", 6, 1, 0, 9);
    take("anom");

    cfg(1, 1, 1, 1, 2, 3, 2, 3);
    send(8'h11, 6'd10);
    result("equal", 10, 0, 0, 9);
    take("equal");

    cfg(1, 1, 0, 1, 3, 3, 3, 3);
    send(8'h77, 6'd10);
    result("tmo", 24, 0, 1, 24);
    take("tmo");

    x_done = 1'b1;
    x_len  = 4'd9;
    @(negedge clk);
    x_done = 1'b0;
    cfg(1, 1, 16, 1, 3, 3, 2, 3);
    send(8'hE1, 6'd12);
    result("coll", 11, 1, 0, 24);
    x_done = 1'b1;
    x_len  = 4'd7;
    @(negedge clk);
    x_done = 1'b0;
    @(negedge clk);
    check("stray_score", int'(r_score), 11);
    check("stray_rvalid", int'(r_valid), 1);
    take("coll");

    cfg(1, 1, 1, 1, 3, 4, 2, 5);
    send(8'h5A, 6'd10);
    result("bp", 14, 0, 0, 9);
    s_data    = 8'hC3;
    threshold = 6'd20;
    s_valid   = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_ready || !r_valid || r_score != 6'd14 ||
          r_anomaly || r_err)
        bad++;
    end
    check("bp_hold", bad, 0);
    exp_data = 8'hC3;
    take("bp");
    acc_cyc  = cyc;
    issued   = 0;
    data_bad = 0;
    @(negedge clk);
    s_valid = 1'b0;
    result("bp_next", 14, 1, 0, 9);
    take("bp_next");

    cfg(1, 5, 1, 1, 1, 1, 1, 1);
    send(8'h99, 6'd10);
    repeat (3) @(negedge clk);
    check("pre_rst_tree", int'(eng_tree), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_s_ready", int'(s_ready), 0);
    check("mid_rst_eng_start", int'(eng_start), 0);
    check("mid_rst_eng_tree", int'(eng_tree), 0);
    check("mid_rst_eng_data", int'(eng_data), 0);
    check("mid_rst_r_valid", int'(r_valid), 0);
    check("mid_rst_r_score", int'(r_score), 0);
    check("mid_rst_r_err", int'(r_err), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_rvalid", int'(r_valid), 0);
    cfg(1, 1, 1, 1, 1, 1, 1, 1);
    send(8'h42, 6'd3);
    result("post_rst", 4, 0, 0, 9);
    take("post_rst");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
